// File: rtl/pc_redirect_ctrl_pkg.sv
// pc_redirect_ctrl_pkg: PC-source select encodings and FSM states shared by the redirect controller.
package pc_redirect_ctrl_pkg;
  typedef enum logic [2:0] {
    PCSEL_INC  = 3'd0,
    PCSEL_RF   = 3'd1,
    PCSEL_MEM  = 3'd2,
    PCSEL_IMM  = 3'd3,
    PCSEL_RRPC = 3'd4,
    PCSEL_LHI  = 3'd5,
    PCSEL_ALU  = 3'd6
  } pcSel_e;
  typedef enum logic {IDLE, MULTI} state_e;
endpackage

// File: rtl/pc_redirect_ctrl_popcount8.sv
// popcount8: combinational count of set bits in an LM/SM register list.
module popcount8 #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) count = count + CW'(bits[i]);
  end
endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: arbitrates ID/RR/EX/MEM redirects into fetch PC select, flushes, and load-use / LM-SM stalls.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int REGLIST_W = 8,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_jal,
  input  logic                 id_lhi_r7,
  input  logic                 rr_jlr,
  input  logic                 rr_multi,
  input  logic [REGLIST_W-1:0] rr_reglist,
  input  logic                 ex_redirect,
  input  logic                 mem_load_r7,
  input  logic                 ld_use_hazard,
  output logic [2:0]           pc_sel,
  output logic                 pc_write,
  output logic                 stall_if_id,
  output logic                 stall_id_rr,
  output logic                 flush_if_id,
  output logic                 flush_id_rr,
  output logic                 flush_rr_ex,
  output logic                 flush_ex_mem,
  output logic                 multi_busy,
  output logic [CNT_W-1:0]     redirect_cnt
);
  localparam int CW = $clog2(REGLIST_W + 1);
  state_e        state, stateNext;
  logic [CW-1:0] count, countNext, popCnt;
  logic          inMulti, lastXfer, lateRedir, earlyRedir, redirect, holdFetch;
  popcount8 #(.W(REGLIST_W), .CW(CW)) uPop (.bits(rr_reglist), .count(popCnt));
  // ID/RR stages are frozen during MULTI, so only EX/MEM redirects can win there.
  always_comb begin
    inMulti      = state == MULTI;
    lastXfer     = inMulti && count == CW'(1);
    lateRedir    = mem_load_r7 || ex_redirect;
    earlyRedir   = !inMulti && (rr_jlr || id_jal || id_lhi_r7);
    redirect     = lateRedir || earlyRedir;
    holdFetch    = !redirect && (inMulti || ld_use_hazard);
    pc_sel       = mem_load_r7 ? PCSEL_MEM : ex_redirect ? PCSEL_ALU : !inMulti && rr_jlr ? PCSEL_RF :
                   !inMulti && id_jal ? PCSEL_IMM : !inMulti && id_lhi_r7 ? PCSEL_LHI :
                   lastXfer ? PCSEL_RRPC : PCSEL_INC;
    pc_write     = redirect || (inMulti ? lastXfer : !ld_use_hazard);
    stall_if_id  = holdFetch;
    stall_id_rr  = holdFetch;
    flush_if_id  = redirect;
    flush_id_rr  = lateRedir || (!inMulti && rr_jlr);
    flush_rr_ex  = lateRedir || (!redirect && !inMulti && ld_use_hazard);
    flush_ex_mem = mem_load_r7;
    multi_busy   = inMulti && !lateRedir;
    stateNext    = inMulti ? ((lateRedir || lastXfer) ? IDLE : MULTI)
                           : ((rr_multi && popCnt > CW'(1) && !lateRedir) ? MULTI : IDLE);
    countNext    = stateNext == IDLE ? '0 : inMulti ? count - CW'(1) : popCnt - CW'(1);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= '0;
      redirect_cnt <= '0;
    end else begin
      state <= stateNext;
      count <= countNext;
      if (redirect && redirect_cnt != '1) redirect_cnt <= redirect_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: table-driven IDLE arbitration vectors plus directed LM/SM, reset and saturation sequences.
module tb_pc_redirect_ctrl;
  logic clk = 1'b0, reset = 1'b0;
  logic id_jal = 0, id_lhi_r7 = 0, rr_jlr = 0, rr_multi = 0, ex_redirect = 0, mem_load_r7 = 0, ld_use_hazard = 0;
  logic [7:0] rr_reglist = '0;
  logic [2:0] pc_sel;
  logic pc_write, stall_if_id, stall_id_rr, flush_if_id, flush_id_rr, flush_rr_ex, flush_ex_mem, multi_busy;
  logic [15:0] redirect_cnt;
  int checks = 0, failures = 0;
  logic [15:0] expCnt = '0;

  pc_redirect_ctrl dut (
    .clk(clk), .reset(reset), .id_jal(id_jal), .id_lhi_r7(id_lhi_r7), .rr_jlr(rr_jlr), .rr_multi(rr_multi),
    .rr_reglist(rr_reglist), .ex_redirect(ex_redirect), .mem_load_r7(mem_load_r7), .ld_use_hazard(ld_use_hazard),
    .pc_sel(pc_sel), .pc_write(pc_write), .stall_if_id(stall_if_id), .stall_id_rr(stall_id_rr),
    .flush_if_id(flush_if_id), .flush_id_rr(flush_id_rr), .flush_rr_ex(flush_rr_ex), .flush_ex_mem(flush_ex_mem),
    .multi_busy(multi_busy), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] in;
    logic [2:0] sel;
    logic       pw;
    logic       stall;
    logic [3:0] fl;
    logic       inc;
  } vec_t;
  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chkComb(input string tag, input logic [2:0] sel, input logic pw, input logic st,
                         input logic [3:0] fl, input logic busy);
    chk({tag, " pc_sel"}, 32'(pc_sel), 32'(sel));
    chk({tag, " pc_write"}, 32'(pc_write), 32'(pw));
    chk({tag, " stalls"}, 32'({stall_if_id, stall_id_rr}), 32'({st, st}));
    chk({tag, " flushes"}, 32'({flush_if_id, flush_id_rr, flush_rr_ex, flush_ex_mem}), 32'(fl));
    chk({tag, " multi_busy"}, 32'(multi_busy), 32'(busy));
  endtask

  task automatic drive(input logic [5:0] v);
    {mem_load_r7, ex_redirect, rr_jlr, id_jal, id_lhi_r7, ld_use_hazard} = v;
  endtask

  task automatic idle();
    drive(6'b0);
    rr_multi = 0;
    rr_reglist = '0;
  endtask

  initial begin
    // in = {mem, ex, rr_jlr, id_jal, lhi, ld}; fl = {if_id, id_rr, rr_ex, ex_mem}
    vecs[0]  = {6'b000000, 3'd0, 1'b1, 1'b0, 4'b0000, 1'b0};
    vecs[1]  = {6'b000001, 3'd0, 1'b0, 1'b1, 4'b0010, 1'b0};
    vecs[2]  = {6'b000100, 3'd3, 1'b1, 1'b0, 4'b1000, 1'b1};
    vecs[3]  = {6'b000010, 3'd5, 1'b1, 1'b0, 4'b1000, 1'b1};
    vecs[4]  = {6'b000110, 3'd3, 1'b1, 1'b0, 4'b1000, 1'b1};
    vecs[5]  = {6'b001100, 3'd1, 1'b1, 1'b0, 4'b1100, 1'b1};
    vecs[6]  = {6'b010000, 3'd6, 1'b1, 1'b0, 4'b1110, 1'b1};
    vecs[7]  = {6'b100000, 3'd2, 1'b1, 1'b0, 4'b1111, 1'b1};
    vecs[8]  = {6'b111100, 3'd2, 1'b1, 1'b0, 4'b1111, 1'b1};
    vecs[9]  = {6'b010001, 3'd6, 1'b1, 1'b0, 4'b1110, 1'b1};
    vecs[10] = {6'b000101, 3'd3, 1'b1, 1'b0, 4'b1000, 1'b1};
    vecs[11] = {6'b001010, 3'd1, 1'b1, 1'b0, 4'b1100, 1'b1};
    vecs[12] = {6'b011000, 3'd6, 1'b1, 1'b0, 4'b1110, 1'b1};

    repeat (2) @(negedge clk);
    #1 chkComb("reset", 3'd0, 1'b1, 1'b0, 4'b0000, 1'b0);
    chk("reset cnt", 32'(redirect_cnt), 32'd0);
    @(negedge clk) reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk) drive(vecs[i].in);
      #1 chkComb($sformatf("vec%0d", i), vecs[i].sel, vecs[i].pw, vecs[i].stall, vecs[i].fl, 1'b0);
      if (vecs[i].inc) expCnt++;
      @(posedge clk) #1 chk($sformatf("vec%0d cnt", i), 32'(redirect_cnt), 32'(expCnt));
    end

    // load-use for one cycle releases fetch the next cycle
    @(negedge clk) begin idle(); ld_use_hazard = 1; end
    #1 chkComb("lu", 3'd0, 1'b0, 1'b1, 4'b0010, 1'b0);
    @(negedge clk) idle();
    #1 chkComb("lu release", 3'd0, 1'b1, 1'b0, 4'b0000, 1'b0);

    // LM with 4 registers: three MULTI cycles, ID redirect ignored mid-sequence
    @(negedge clk) begin rr_multi = 1; rr_reglist = 8'b1011_0001; end
    #1 chkComb("lm entry", 3'd0, 1'b1, 1'b0, 4'b0000, 1'b0);
    @(negedge clk) idle();
    #1 chkComb("lm c3", 3'd0, 1'b0, 1'b1, 4'b0000, 1'b1);
    @(negedge clk) id_jal = 1;
    #1 chkComb("lm c2 jal", 3'd0, 1'b0, 1'b1, 4'b0000, 1'b1);
    @(negedge clk) idle();
    chk("lm jal ignored cnt", 32'(redirect_cnt), 32'(expCnt));
    #1 chkComb("lm c1", 3'd4, 1'b1, 1'b1, 4'b0000, 1'b1);
    @(negedge clk) #1 chkComb("lm done", 3'd0, 1'b1, 1'b0, 4'b0000, 1'b0);

    // popcount 1 and 0 never enter MULTI
    @(negedge clk) begin rr_multi = 1; rr_reglist = 8'b0000_1000; end
    @(negedge clk) begin rr_reglist = 8'b0; end
    #1 chk("pop1 busy", 32'(multi_busy), 32'd0);
    @(negedge clk) idle();
    #1 chk("pop0 busy", 32'(multi_busy), 32'd0);

    // entry suppressed by a simultaneous EX redirect
    @(negedge clk) begin rr_multi = 1; rr_reglist = 8'hF0; ex_redirect = 1; end
    expCnt++;
    @(negedge clk) idle();
    #1 chkComb("blocked entry", 3'd0, 1'b1, 1'b0, 4'b0000, 1'b0);

    // MULTI count=2 aborted by EX redirect
    @(negedge clk) begin rr_multi = 1; rr_reglist = 8'b0000_0111; end
    @(negedge clk) begin idle(); ex_redirect = 1; end
    #1 chkComb("abort", 3'd6, 1'b1, 1'b0, 4'b1110, 1'b0);
    expCnt++;
    @(negedge clk) idle();
    #1 chkComb("after abort", 3'd0, 1'b1, 1'b0, 4'b0000, 1'b0);
    chk("abort cnt", 32'(redirect_cnt), 32'(expCnt));

    // asynchronous reset mid-MULTI (count=3)
    @(negedge clk) begin rr_multi = 1; rr_reglist = 8'b1011_0001; end
    @(negedge clk) idle();
    #1 chk("pre-reset busy", 32'(multi_busy), 32'd1);
    #2 reset = 1'b0;
    #1 chkComb("async reset", 3'd0, 1'b1, 1'b0, 4'b0000, 1'b0);
    chk("async reset cnt", 32'(redirect_cnt), 32'd0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) #1 chkComb("post reset", 3'd0, 1'b1, 1'b0, 4'b0000, 1'b0);

    // saturation of the redirect counter
    @(negedge clk) mem_load_r7 = 1;
    repeat (65534) @(posedge clk);
    #1 chk("cnt FFFE", 32'(redirect_cnt), 32'hFFFE);
    @(posedge clk) #1 chk("cnt FFFF", 32'(redirect_cnt), 32'hFFFF);
    repeat (3) @(posedge clk);
    #1 chk("cnt saturated", 32'(redirect_cnt), 32'hFFFF);
    @(negedge clk) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
